pc_ras_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage, replacing the fixed 32-bit PC. It holds the current fetch address and computes the next one from a single operation code: increment, PC-relative branch, absolute jump, register jump, call or return. It adds a circular return-address stack (RAS) so calls and returns resolve without a register read, plus stall, alignment and overflow reporting. It sits between the decode/branch-resolution logic and the instruction-memory address port.

---
 rtl/pc_ras_unit_pkg.sv | 25 ++
 rtl/pc_ras_unit_ras_lifo.sv | 74 +++++++
 rtl/pc_ras_unit.sv | 115 +++++++++++
 tb/tb_pc_ras_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_ras_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the fetch-stage PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Program-counter operation selected by decode / branch resolution
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_JREG   = 3'd4,
        PC_CALL   = 3'd5,
        PC_CALLR  = 3'd6,
        PC_RET    = 3'd7
    } pc_op_e;

    // Bytes per instruction; sequential fetch and link addresses step by this
    localparam int INSTR_BYTES = 4;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras_unit_ras_lifo.sv
`default_nettype none
// ============================================================================
// Module      : ras_lifo
// Description : Circular return-address stack. A push onto a full stack
//               overwrites the oldest entry and sets a sticky overflow flag;
//               a pop from an empty stack is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_lifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int                     c_ptr_w = $clog2(DEPTH);
    localparam int                     c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0]     c_full  = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic [c_ptr_w-1:0] w_push_ptr;
    logic               w_full;
    logic               w_empty;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    // When full, the slot after the top is the oldest entry, which a push
    // then overwrites.
    assign w_push_ptr = r_top + c_ptr_w'(1);
    assign w_full     = (r_count == c_full);
    assign w_empty    = (r_count == '0);

    // Entry storage: written on push only, never cleared (unreachable while empty)
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_push_ptr] <= push_data;
        end
    end

    // Top pointer, occupancy count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (push) begin
            r_top <= w_push_ptr;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (pop && !w_empty) begin
            r_top   <= r_top - c_ptr_w'(1);
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign top_data = r_mem[r_top];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule : ras_lifo
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit
// Description : Fetch-stage program counter with next-PC selection, a
//               circular return-address stack for call/return, stall
//               support, and misalignment / overflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          IMM_W     = 16,
    parameter int          JMP_W     = 26,
    parameter int          RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  pc_op_e                       pc_op,
    input  logic [XLEN-1:0]              rs1_val,
    input  logic [IMM_W-1:0]             immediate,
    input  logic [JMP_W-1:0]             target,
    output logic [XLEN-1:0]              pc_val,
    output logic [XLEN-1:0]              link_addr,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         misaligned
);

    localparam int c_cnt_w = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0]    r_pc;
    logic               r_misaligned;

    logic [XLEN-1:0]    w_pc_plus4;
    logic [XLEN-1:0]    w_branch_off;
    logic [XLEN-1:0]    w_branch_pc;
    logic [XLEN-1:0]    w_jump_pc;
    logic [XLEN-1:0]    w_reg_pc;
    logic [XLEN-1:0]    w_next_pc;
    logic [XLEN-1:0]    w_ras_top;
    logic [c_cnt_w-1:0] w_ras_count;
    logic               w_ras_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_uses_rs1;

    // Candidate targets; arithmetic wraps modulo 2^XLEN
    assign w_pc_plus4   = r_pc + XLEN'(INSTR_BYTES);
    assign w_branch_off = {{(XLEN-IMM_W){immediate[IMM_W-1]}}, immediate} << 2;
    assign w_branch_pc  = w_pc_plus4 + w_branch_off;
    assign w_jump_pc    = {w_pc_plus4[XLEN-1:JMP_W+2], target, 2'b00};
    assign w_reg_pc     = {rs1_val[XLEN-1:2], 2'b00};
    assign w_ras_empty  = (w_ras_count == '0);

    // Stack actions follow the op only when the cycle is not stalled
    assign w_push = enable && ((pc_op == PC_CALL) || (pc_op == PC_CALLR));
    assign w_pop  = enable && (pc_op == PC_RET) && !w_ras_empty;

    // Ops whose target comes from rs1 (including RET falling back on an empty stack)
    assign w_uses_rs1 = (pc_op == PC_JREG) || (pc_op == PC_CALLR) ||
                        ((pc_op == PC_RET) && w_ras_empty);

    // Next-PC selection
    always_comb begin
        w_next_pc = r_pc;
        case (pc_op)
            PC_HOLD:   w_next_pc = r_pc;
            PC_INC:    w_next_pc = w_pc_plus4;
            PC_BRANCH: w_next_pc = w_branch_pc;
            PC_JUMP:   w_next_pc = w_jump_pc;
            PC_JREG:   w_next_pc = w_reg_pc;
            PC_CALL:   w_next_pc = w_jump_pc;
            PC_CALLR:  w_next_pc = w_reg_pc;
            PC_RET:    w_next_pc = w_ras_empty ? w_reg_pc : w_ras_top;
            default:   w_next_pc = r_pc;
        endcase
    end

    // PC register and one-cycle misalignment pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else if (enable) begin
            r_pc         <= w_next_pc;
            r_misaligned <= w_uses_rs1 && (rs1_val[1:0] != 2'b00);
        end else begin
            r_misaligned <= 1'b0;
        end
    end

    ras_lifo #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus4),
        .top_data  (w_ras_top),
        .count     (w_ras_count),
        .overflow  (ras_overflow)
    );

    assign pc_val     = r_pc;
    assign link_addr  = w_pc_plus4;
    assign ras_count  = w_ras_count;
    assign misaligned = r_misaligned;

endmodule : pc_ras_unit
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ras_unit
// Description : Directed, table-driven self-checking bench for pc_ras_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ras_unit;
    import pc_pkg::*;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
        logic        exp_mis;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    pc_op_e      pc_op;
    logic [31:0] rs1_val;
    logic [15:0] immediate;
    logic [25:0] target;
    logic [31:0] pc_val;
    logic [31:0] link_addr;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        misaligned;

    int checks;
    int errors;
    vec_t vecs[$];

    pc_ras_unit dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pc_op        (pc_op),
        .rs1_val      (rs1_val),
        .immediate    (immediate),
        .target       (target),
        .pc_val       (pc_val),
        .link_addr    (link_addr),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .misaligned   (misaligned)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                               input logic ovf, input logic mis);
        chk({tag, " pc_val"},       pc_val,              pc);
        chk({tag, " link_addr"},    link_addr,           pc + 32'd4);
        chk({tag, " ras_count"},    {29'd0, ras_count},  {29'd0, cnt});
        chk({tag, " ras_overflow"}, {31'd0, ras_overflow}, {31'd0, ovf});
        chk({tag, " misaligned"},   {31'd0, misaligned}, {31'd0, mis});
    endtask

    // Drive one cycle of inputs, let the edge pass, then sample
    task automatic step(input logic en, input logic [2:0] op, input logic [31:0] rs1,
                        input logic [15:0] imm, input logic [25:0] tgt);
        enable    = en;
        pc_op     = pc_op_e'(op);
        rs1_val   = rs1;
        immediate = imm;
        target    = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [2:0] op, input logic [31:0] rs1,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] pc,
                       input logic [2:0] cnt, input logic ovf, input logic mis);
        vec_t v;
        v.en = en; v.op = op; v.rs1 = rs1; v.imm = imm; v.tgt = tgt;
        v.exp_pc = pc; v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_mis = mis;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //   en  op  rs1           imm       tgt        exp_pc        cnt ovf mis
        add(1, 1, 32'h0,        16'h0,    26'h0,     32'h0000_0004, 0, 0, 0);  // INC
        add(1, 1, 32'h0,        16'h0,    26'h0,     32'h0000_0008, 0, 0, 0);
        add(1, 1, 32'h0,        16'h0,    26'h0,     32'h0000_000C, 0, 0, 0);
        add(1, 1, 32'h0,        16'h0,    26'h0,     32'h0000_0010, 0, 0, 0);
        add(0, 1, 32'h0,        16'h0,    26'h0,     32'h0000_0010, 0, 0, 0);  // stall
        add(0, 1, 32'h0,        16'h0,    26'h0,     32'h0000_0010, 0, 0, 0);
        add(1, 2, 32'h0,        16'hDEAD, 26'h0,     32'hFFFF_7AC8, 0, 0, 0);  // BRANCH
        add(1, 4, 32'h10,       16'h0,    26'h0,     32'h0000_0010, 0, 0, 0);  // JREG back
        add(1, 3, 32'h0,        16'h0,    26'h1,     32'h0000_0004, 0, 0, 0);  // JUMP
        add(1, 4, 32'hDEADBEEF, 16'h0,    26'h0,     32'hDEAD_BEEC, 0, 0, 1);  // JREG misaligned
        add(1, 1, 32'h0,        16'h0,    26'h0,     32'hDEAD_BEF0, 0, 0, 0);  // pulse ends
        add(1, 4, 32'h100,      16'h0,    26'h0,     32'h0000_0100, 0, 0, 0);
        add(1, 5, 32'h0,        16'h0,    26'h80,    32'h0000_0200, 1, 0, 0);  // CALL x5
        add(1, 5, 32'h0,        16'h0,    26'hC0,    32'h0000_0300, 2, 0, 0);
        add(1, 5, 32'h0,        16'h0,    26'h100,   32'h0000_0400, 3, 0, 0);
        add(1, 5, 32'h0,        16'h0,    26'h140,   32'h0000_0500, 4, 0, 0);
        add(1, 5, 32'h0,        16'h0,    26'h180,   32'h0000_0600, 4, 1, 0);  // overflow
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0504, 3, 1, 0);  // RET x4
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0404, 2, 1, 0);
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0304, 1, 1, 0);
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0204, 0, 1, 0);
        add(1, 7, 32'h40,       16'h0,    26'h0,     32'h0000_0040, 0, 1, 0);  // empty RET
        add(1, 7, 32'h43,       16'h0,    26'h0,     32'h0000_0040, 0, 1, 1);  // empty RET, misaligned
        add(1, 5, 32'h0,        16'h0,    26'h10,    32'h0000_0040, 1, 1, 0);  // CALL pushes 0x44
        add(0, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0040, 1, 1, 0);  // stalled RET
        add(0, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0040, 1, 1, 0);
        add(0, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0040, 1, 1, 0);
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0044, 0, 1, 0);  // RET
        add(1, 6, 32'h1003,     16'h0,    26'h0,     32'h0000_1000, 1, 1, 1);  // CALLR pushes 0x48
        add(1, 7, 32'h0,        16'h0,    26'h0,     32'h0000_0048, 0, 1, 0);
        add(1, 0, 32'h0,        16'h0,    26'h0,     32'h0000_0048, 0, 1, 0);  // HOLD

        // Reset state
        reset = 1'b1;
        step(1'b0, 3'd0, 32'h0, 16'h0, 26'h0);
        step(1'b0, 3'd0, 32'h0, 16'h0, 26'h0);
        reset = 1'b0;
        check_state("reset", 32'h0, 3'd0, 1'b0, 1'b0);

        // Table-driven sequence
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].op, vecs[i].rs1, vecs[i].imm, vecs[i].tgt);
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                        vecs[i].exp_ovf, vecs[i].exp_mis);
        end

        // Reset mid call sequence: pending returns discarded, overflow cleared,
        // reset wins over an enabled CALL on the same edge
        step(1'b1, 3'd5, 32'h0, 16'h0, 26'h200);
        check_state("pre-rst call1", 32'h0000_0800, 3'd1, 1'b1, 1'b0);
        step(1'b1, 3'd5, 32'h0, 16'h0, 26'h300);
        check_state("pre-rst call2", 32'h0000_0C00, 3'd2, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 3'd5, 32'h0, 16'h0, 26'h300);
        reset = 1'b0;
        check_state("mid-rst", 32'h0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'h80, 16'h0, 26'h0);
        check_state("post-rst ret", 32'h0000_0080, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_ras_unit
`default_nettype wire
